// File: rtl/blend_packer_if.sv
// Pixel-stream and frame-buffer write bus for blend_packer.
// slave: the packer (consumes pixels, drives FIFO writes); master: the upstream/FIFO side.
interface blend_packer_if;
    logic        val;
    logic [9:0]  sync_x;
    logic [9:0]  sync_y;
    logic [4:0]  dvi_r;
    logic [5:0]  dvi_g;
    logic [4:0]  dvi_b;
    logic [4:0]  ccd_r;
    logic [5:0]  ccd_g;
    logic [4:0]  ccd_b;
    logic [1:0]  mode;
    logic        wrfull;
    logic        wrreq;
    logic [31:0] data;
    logic [17:0] wr_addr;

    modport master (
        output val, sync_x, sync_y, dvi_r, dvi_g, dvi_b, ccd_r, ccd_g, ccd_b, mode, wrfull,
        input  wrreq, data, wr_addr
    );

    modport slave (
        input  val, sync_x, sync_y, dvi_r, dvi_g, dvi_b, ccd_r, ccd_g, ccd_b, mode, wrfull,
        output wrreq, data, wr_addr
    );
endinterface

// File: rtl/blend_packer.sv
// Blends DVI/CCD RGB565 pixels and packs x-adjacent pairs into 32-bit frame-buffer words.
// Optional: define BLEND_PACKER_DIFF_EN to build absolute difference for mode 11 (else average).
module blend_packer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk_25,
    input  logic        rst_n,
    blend_packer_if.slave bus,
    output logic        frame_done,
    output logic        overflow,
    output logic        misalign,
    output logic [15:0] drop_count
);

    localparam logic [0:0]  S_IDLE     = 1'b0;
    localparam logic [0:0]  S_FRAME    = 1'b1;
    localparam logic [9:0]  X_LIM      = 10'(H_ACTIVE);
    localparam logic [9:0]  Y_LIM      = 10'(V_ACTIVE);
    localparam logic [9:0]  X_LAST     = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_LAST     = 10'(V_ACTIVE - 1);
    localparam logic [17:0] LINE_WORDS = 18'(H_ACTIVE / 2);

    function automatic logic [15:0] blend565(input logic [15:0] d, input logic [15:0] c,
                                             input logic [1:0] m);
        logic [5:0]  sr;
        logic [6:0]  sg;
        logic [5:0]  sb;
        logic [15:0] res;
        sr = {1'b0, d[15:11]} + {1'b0, c[15:11]};
        sg = {1'b0, d[10:5]}  + {1'b0, c[10:5]};
        sb = {1'b0, d[4:0]}   + {1'b0, c[4:0]};
        case (m)
            2'b00: res = d;
            2'b01: res = c;
`ifdef BLEND_PACKER_DIFF_EN
            2'b11: res = {(d[15:11] >= c[15:11]) ? d[15:11] - c[15:11] : c[15:11] - d[15:11],
                          (d[10:5]  >= c[10:5])  ? d[10:5]  - c[10:5]  : c[10:5]  - d[10:5],
                          (d[4:0]   >= c[4:0])   ? d[4:0]   - c[4:0]   : c[4:0]   - d[4:0]};
`endif
            default: res = {5'(sr >> 1), 6'(sg >> 1), 5'(sb >> 1)};
        endcase
        return res;
    endfunction

    function automatic logic [17:0] word_addr(input logic [9:0] y, input logic [8:0] col);
        return 18'(y) * LINE_WORDS + 18'(col);
    endfunction

    logic [0:0]  state;
    logic        in_range, at_origin, at_last, accept;

    logic        s1_v;
    logic [9:0]  s1_x, s1_y;
    logic [15:0] s1_pix;

    logic        pend_v;
    logic [8:0]  pend_col;
    logic [9:0]  pend_y;
    logic [15:0] pend_pix;

    logic        s1_odd, pair_ok, form, fault, last_word;
    logic [31:0] word;
    logic [17:0] addr;

    always_comb begin
        in_range  = (bus.sync_x < X_LIM) && (bus.sync_y < Y_LIM);
        at_origin = (bus.sync_x == '0) && (bus.sync_y == '0);
        at_last   = (bus.sync_x == X_LAST) && (bus.sync_y == Y_LAST);
        accept    = bus.val && in_range && ((state == S_FRAME) || at_origin);
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            s1_v   <= 1'b0;
            s1_x   <= '0;
            s1_y   <= '0;
            s1_pix <= '0;
        end else begin
            s1_v <= accept;
            if (accept) begin
                s1_x   <= bus.sync_x;
                s1_y   <= bus.sync_y;
                s1_pix <= blend565({bus.dvi_r, bus.dvi_g, bus.dvi_b},
                                   {bus.ccd_r, bus.ccd_g, bus.ccd_b}, bus.mode);
                state  <= at_last ? S_IDLE : S_FRAME;
            end
        end
    end

    // An even pixel displacing a pending one flushes the pending half-word at its own address.
    always_comb begin
        s1_odd    = s1_x[0];
        pair_ok   = pend_v && (pend_y == s1_y) && (pend_col == s1_x[9:1]);
        form      = s1_v && (s1_odd || pend_v);
        last_word = s1_v && s1_odd && (s1_x == X_LAST) && (s1_y == Y_LAST);
        if (s1_odd) begin
            word  = pair_ok ? {pend_pix, s1_pix} : {16'h0000, s1_pix};
            addr  = word_addr(s1_y, s1_x[9:1]);
            fault = !pair_ok;
        end else begin
            word  = {pend_pix, 16'h0000};
            addr  = word_addr(pend_y, pend_col);
            fault = pend_v;
        end
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            pend_v   <= 1'b0;
            pend_col <= '0;
            pend_y   <= '0;
            pend_pix <= '0;
        end else if (s1_v) begin
            if (!s1_odd) begin
                pend_v   <= 1'b1;
                pend_col <= s1_x[9:1];
                pend_y   <= s1_y;
                pend_pix <= s1_pix;
            end else if (pair_ok) begin
                pend_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            bus.wrreq   <= 1'b0;
            bus.data    <= '0;
            bus.wr_addr <= '0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            misalign    <= 1'b0;
            drop_count  <= '0;
        end else begin
            bus.wrreq  <= form && !bus.wrfull;
            frame_done <= last_word;
            if (form) begin
                bus.data    <= word;
                bus.wr_addr <= addr;
            end
            if (form && bus.wrfull) begin
                overflow <= 1'b1;
                if (drop_count != '1)
                    drop_count <= drop_count + 16'd1;
            end
            if (form && fault)
                misalign <= 1'b1;
        end
    end

endmodule

// File: tb/tb_blend_packer.sv
// Directed bench for blend_packer: vector table for blend modes plus hand sequences
// for backpressure, pairing faults, frame sync, frame end and mid-frame reset.
module tb_blend_packer;

    logic        clk_25 = 1'b0;
    logic        rst_n  = 1'b0;
    logic        frame_done, overflow, misalign;
    logic [15:0] drop_count;

    blend_packer_if bif ();

    blend_packer #(.H_ACTIVE(640), .V_ACTIVE(480)) dut (
        .clk_25     (clk_25),
        .rst_n      (rst_n),
        .bus        (bif),
        .frame_done (frame_done),
        .overflow   (overflow),
        .misalign   (misalign),
        .drop_count (drop_count)
    );

    always #20 clk_25 = ~clk_25;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] dvi_e, ccd_e, dvi_o, ccd_o;
        logic [31:0] exp;
    } vec_t;

`ifdef BLEND_PACKER_DIFF_EN
    localparam logic [15:0] M3_MIX = 16'hF7EA;
    localparam logic [15:0] M3_MAX = 16'hFFFF;
`else
    localparam logic [15:0] M3_MIX = 16'h83EF;
    localparam logic [15:0] M3_MAX = 16'h7BEF;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;
    logic fd_wr  = 1'b0;
    logic [31:0] wq_data[$];
    logic [17:0] wq_addr[$];

    always @(negedge clk_25) begin
        if (bif.wrreq) begin
            wq_data.push_back(bif.data);
            wq_addr.push_back(bif.wr_addr);
        end
        if (frame_done) begin
            fd_cnt = fd_cnt + 1;
            fd_wr  = bif.wrreq;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic expect_word(input string name, input logic [31:0] d, input logic [17:0] a);
        if (wq_data.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no word, expected %h @ %0d", name, d, a);
        end else begin
            check({name, " data"}, wq_data.pop_front(), d);
            check({name, " addr"}, 32'(wq_addr.pop_front()), 32'(a));
        end
    endtask

    task automatic expect_none(input string name);
        check(name, 32'(wq_data.size()), 32'd0);
        wq_data.delete();
        wq_addr.delete();
    endtask

    task automatic pix(input int x, input int y, input logic [15:0] d, input logic [15:0] c,
                       input logic [1:0] m);
        bif.val    = 1'b1;
        bif.sync_x = 10'(x);
        bif.sync_y = 10'(y);
        {bif.dvi_r, bif.dvi_g, bif.dvi_b} = d;
        {bif.ccd_r, bif.ccd_g, bif.ccd_b} = c;
        bif.mode   = m;
        @(posedge clk_25); #1;
        bif.val = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_25); #1; end
    endtask

    task automatic check_flags(input string tag, input logic ov, input logic mis,
                               input logic [15:0] dc);
        check({tag, " overflow"}, 32'(overflow), 32'(ov));
        check({tag, " misalign"}, 32'(misalign), 32'(mis));
        check({tag, " drop_count"}, 32'(drop_count), 32'(dc));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        vecs[0] = '{2'b00, 16'hF80A, 16'h0FF4, 16'h1234, 16'hFFFF, 32'hF80A1234};
        vecs[1] = '{2'b01, 16'hF80A, 16'h0FF4, 16'h0000, 16'hABCD, 32'h0FF4ABCD};
        vecs[2] = '{2'b10, 16'hF80A, 16'h0FF4, 16'hF80A, 16'h0FF4, 32'h83EF83EF};
        vecs[3] = '{2'b11, 16'hF80A, 16'h0FF4, 16'hF80A, 16'h0FF4, {M3_MIX, M3_MIX}};
        vecs[4] = '{2'b10, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFFFFFF};
        vecs[5] = '{2'b11, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, {M3_MAX, M3_MAX}};
        vecs[6] = '{2'b11, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, {M3_MAX, M3_MAX}};

        bif.val = 1'b0; bif.sync_x = '0; bif.sync_y = '0; bif.mode = '0; bif.wrfull = 1'b0;
        {bif.dvi_r, bif.dvi_g, bif.dvi_b} = '0;
        {bif.ccd_r, bif.ccd_g, bif.ccd_b} = '0;

        // Reset state
        repeat (2) @(posedge clk_25);
        @(negedge clk_25);
        check("reset wrreq", 32'(bif.wrreq), 32'd0);
        check("reset data", bif.data, 32'd0);
        check("reset wr_addr", 32'(bif.wr_addr), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        check_flags("reset", 1'b0, 1'b0, 16'd0);
        @(posedge clk_25); #1;
        rst_n = 1'b1;
        idle(2);

        // Pixels before (0,0) are ignored
        pix(2, 0, 16'h1111, 16'h0, 2'b00);
        pix(3, 0, 16'h2222, 16'h0, 2'b00);
        pix(1, 0, 16'h3333, 16'h0, 2'b00);
        idle(4);
        expect_none("pre-frame ignored");

        // Blend table on line 0
        pix(0, 0, 16'h1111, 16'h0, 2'b00);
        pix(1, 0, 16'h2222, 16'h0, 2'b00);
        for (int unsigned k = 0; k < 7; k++) begin
            pix(2 + 2 * int'(k), 0, vecs[k].dvi_e, vecs[k].ccd_e, vecs[k].mode);
            pix(3 + 2 * int'(k), 0, vecs[k].dvi_o, vecs[k].ccd_o, vecs[k].mode);
        end
        idle(4);
        expect_word("first word", 32'h11112222, 18'd0);
        for (int unsigned k = 0; k < 7; k++)
            expect_word($sformatf("vec%0d", k), vecs[k].exp, 18'(k + 1));
        expect_none("table extra words");

        // Latency: odd pixel at cycle t -> wrreq at t+2
        pix(16, 0, 16'hAAAA, 16'h0, 2'b00);
        pix(17, 0, 16'h5555, 16'h0, 2'b00);
        @(negedge clk_25);
        check("latency t+1 wrreq", 32'(bif.wrreq), 32'd0);
        @(negedge clk_25);
        check("latency t+2 wrreq", 32'(bif.wrreq), 32'd1);
        check("latency t+2 data", bif.data, 32'hAAAA5555);
        check("latency t+2 addr", 32'(bif.wr_addr), 32'd8);
        @(posedge clk_25); #1;
        idle(2);
        wq_data.delete(); wq_addr.delete();

        // Out-of-range pixels are dropped silently
        pix(640, 0, 16'h1, 16'h0, 2'b00);
        pix(641, 0, 16'h2, 16'h0, 2'b00);
        pix(2, 480, 16'h3, 16'h0, 2'b00);
        pix(3, 480, 16'h4, 16'h0, 2'b00);
        idle(4);
        expect_none("out of range");
        check_flags("out of range", 1'b0, 1'b0, 16'd0);

        // Backpressure: words 2..4 of line 1 see wrfull
        for (int x = 0; x < 16; x++) begin
            bif.wrfull = (x >= 6 && x <= 11);
            pix(x, 1, 16'h4000 | 16'(x), 16'h0, 2'b00);
        end
        bif.wrfull = 1'b0;
        idle(4);
        for (int k = 0; k < 8; k++)
            if (k < 2 || k > 4)
                expect_word($sformatf("bp word%0d", k),
                            {16'h4000 | 16'(2 * k), 16'h4000 | 16'(2 * k + 1)}, 18'(320 + k));
        expect_none("bp extra words");
        check_flags("backpressure", 1'b1, 1'b0, 16'd3);

        // Pairing faults on line 2
        pix(4, 2, 16'h0404, 16'h0, 2'b00);
        pix(6, 2, 16'h0606, 16'h0, 2'b00);
        pix(9, 2, 16'h0909, 16'h0, 2'b00);
        pix(7, 2, 16'h0707, 16'h0, 2'b00);
        idle(4);
        expect_word("flush p4", 32'h04040000, 18'd642);
        expect_word("orphan p9", 32'h00000909, 18'd644);
        expect_word("late pair p6p7", 32'h06060707, 18'd643);
        expect_none("misalign extra words");
        check_flags("misalign", 1'b1, 1'b1, 16'd3);

        // Frame end, then back to idle
        pix(638, 479, 16'hF800, 16'h0, 2'b00);
        pix(639, 479, 16'h07E0, 16'h0, 2'b00);
        idle(4);
        expect_word("last word", 32'hF80007E0, 18'd153599);
        check("frame_done count", 32'(fd_cnt), 32'd1);
        check("frame_done with wrreq", 32'(fd_wr), 32'd1);
        pix(2, 3, 16'h1, 16'h0, 2'b00);
        pix(3, 3, 16'h2, 16'h0, 2'b00);
        idle(4);
        expect_none("post-frame ignored");

        // Frame whose last word is dropped still pulses frame_done
        pix(0, 0, 16'h0101, 16'h0, 2'b00);
        pix(1, 0, 16'h0202, 16'h0, 2'b00);
        pix(638, 479, 16'h0303, 16'h0, 2'b00);
        pix(639, 479, 16'h0404, 16'h0, 2'b00);
        bif.wrfull = 1'b1;
        idle(1);
        bif.wrfull = 1'b0;
        idle(3);
        expect_word("frame2 first", 32'h01010202, 18'd0);
        expect_none("frame2 last dropped");
        check("frame_done dropped count", 32'(fd_cnt), 32'd2);
        check("frame_done dropped wrreq", 32'(fd_wr), 32'd0);
        check_flags("frame2", 1'b1, 1'b1, 16'd4);

        // Mid-frame reset discards the pending pixel
        pix(0, 0, 16'h0A0A, 16'h0, 2'b00);
        pix(1, 0, 16'h0B0B, 16'h0, 2'b00);
        pix(10, 5, 16'h0C0C, 16'h0, 2'b00);
        idle(2);
        expect_word("pre-reset word", 32'h0A0A0B0B, 18'd0);
        rst_n = 1'b0;
        @(negedge clk_25);
        check("mid reset wrreq", 32'(bif.wrreq), 32'd0);
        check("mid reset data", bif.data, 32'd0);
        check("mid reset addr", 32'(bif.wr_addr), 32'd0);
        check_flags("mid reset", 1'b0, 1'b0, 16'd0);
        @(posedge clk_25); #1;
        rst_n = 1'b1;
        idle(4);
        expect_none("no flush after reset");
        pix(0, 0, 16'h0D0D, 16'h0, 2'b00);
        pix(1, 0, 16'h0E0E, 16'h0, 2'b00);
        idle(4);
        expect_word("clean restart", 32'h0D0D0E0E, 18'd0);
        expect_none("restart extra words");
        check_flags("restart", 1'b0, 1'b0, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
